// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing one registered datapath stage
// (a DATA_W-bit D-register) between NUM_REQ requesters. The winner's data is
// driven on reg_wdata. The register output is compared against it to confirm
// the capture. Then a one-cycle req_ready completes the handshake.
// Repeated capture failures abort the grant with a one-cycle err pulse.
// Optional feature: define ARB_GRANT_CNT_EN to add a saturating 16-bit
// grant_count output that counts successful transfers.
module reg_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [DATA_W-1:0]          reg_wdata,
   input  logic [DATA_W-1:0]          reg_rdata,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       err
`ifdef ARB_GRANT_CNT_EN
   ,
   output logic [15:0]                grant_count
`endif
);

   localparam int ID_W   = $clog2(NUM_REQ);
   localparam int CAND_W = ID_W + 1;
   localparam logic [3:0] LAST_RETRY = 4'(MAX_RETRY - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      CHECK
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ID_W-1:0]   rr_ptr;
   logic [3:0]        retry;
   logic [ID_W-1:0]   winner;
   logic              any_valid;
   logic [CAND_W-1:0] cand;
   logic              load_grant;
   logic              retry_inc;
   logic              release_grant;
   logic              transfer_ok;

   // Round-robin search: scan from the farthest candidate back to pointer+1 so the
   // nearest valid requester after the pointer is the one left in winner.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      cand      = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = {1'b0, rr_ptr} + CAND_W'(i);
         if (cand >= CAND_W'(NUM_REQ)) begin
            cand = cand - CAND_W'(NUM_REQ);
         end
         if (req_valid[cand[ID_W-1:0]]) begin
            any_valid = 1'b1;
            winner    = cand[ID_W-1:0];
         end
      end
   end

   // State register; an asynchronous reset abandons any grant in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the combinational handshake/err pulses issued in CHECK.
   always_comb begin
      state_next    = state;
      req_ready     = '0;
      err           = 1'b0;
      load_grant    = 1'b0;
      retry_inc     = 1'b0;
      release_grant = 1'b0;
      transfer_ok   = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid) begin
               load_grant = 1'b1;
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            state_next = CHECK;
         end
         CHECK: begin
            if (reg_rdata == reg_wdata) begin
               req_ready     = NUM_REQ'(1) << grant_id;
               transfer_ok   = 1'b1;
               release_grant = 1'b1;
               state_next    = IDLE;
            end else if (retry == LAST_RETRY) begin
               err           = 1'b1;
               release_grant = 1'b1;
               state_next    = IDLE;
            end else begin
               retry_inc  = 1'b1;
               state_next = DRIVE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Grant bookkeeping: latch winner and its data, count retries, and move the
   // pointer to the finished grant (aborted ones too, so a stuck requester
   // cannot starve the others).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_wdata <= '0;
         grant_id  <= '0;
         retry     <= '0;
         rr_ptr    <= ID_W'(NUM_REQ - 1);
      end else begin
         if (load_grant) begin
            grant_id  <= winner;
            reg_wdata <= req_data[int'(winner)*DATA_W +: DATA_W];
            retry     <= '0;
         end
         if (retry_inc) begin
            retry <= retry + 4'd1;
         end
         if (release_grant) begin
            rr_ptr <= grant_id;
         end
      end
   end

   assign busy = (state != IDLE);

`ifdef ARB_GRANT_CNT_EN
   // Saturating count of successful transfers; aborted grants are not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_count <= '0;
      end else if (transfer_ok && (grant_count != 16'hFFFF)) begin
         grant_count <= grant_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: table-driven, hand-written and randomized checks for
// reg_write_arbiter. A model of the shared register sits on reg_wdata/reg_rdata.
// The 'stuck' control forces the read-back to zero to provoke capture failures.
// Build with ARB_GRANT_CNT_EN defined to also check grant_count.
module tb_reg_write_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 4;
   localparam int MAX_RETRY = 3;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         reg_wdata;
   logic [DATA_W-1:0]         reg_rdata;
   logic [1:0]                grant_id;
   logic                      busy;
   logic                      err;
`ifdef ARB_GRANT_CNT_EN
   logic [15:0]               grant_count;
`endif

   logic                      stuck;
   logic [DATA_W-1:0]         shared_q;
   int                        checks;
   int                        errors;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] data;
      logic        stuck;
      int          grant;
      logic [3:0]  wdata;
      logic        ok;
   } vec_t;

   vec_t vecs[10];

   reg_write_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .reg_wdata   (reg_wdata),
      .reg_rdata   (reg_rdata),
      .grant_id    (grant_id),
      .busy        (busy),
      .err         (err)
`ifdef ARB_GRANT_CNT_EN
      ,
      .grant_count (grant_count)
`endif
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared register: captures reg_wdata every edge; read-back can be forced to 0.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         shared_q <= '0;
      end else begin
         shared_q <= reg_wdata;
      end
   end

   assign reg_rdata = stuck ? '0 : shared_q;

   // Hard time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected normal finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_data  = '0;
      stuck     = 1'b0;
      reset     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic apply_stimulus(input vec_t v, input int n);
      int len;
      len = v.ok ? 2 : 2 * MAX_RETRY;
      step();
      req_valid = v.valid;
      req_data  = v.data;
      stuck     = v.stuck;
      sample();
      check_output($sformatf("v%0d idle busy", n), 32'(busy), 32'(0));
      step();
      sample();
      check_output($sformatf("v%0d grant_id", n), 32'(grant_id), 32'(v.grant));
      check_output($sformatf("v%0d reg_wdata", n), 32'(reg_wdata), 32'(v.wdata));
      check_output($sformatf("v%0d busy", n), 32'(busy), 32'(1));
      for (int c = 2; c <= len; c++) begin
         step();
         sample();
         if (c < len) begin
            check_output($sformatf("v%0d c%0d ready", n, c), 32'(req_ready), 32'(0));
            check_output($sformatf("v%0d c%0d err", n, c), 32'(err), 32'(0));
         end else begin
            check_output($sformatf("v%0d end ready", n), 32'(req_ready),
                         v.ok ? 32'(4'(1) << v.grant) : 32'(0));
            check_output($sformatf("v%0d end err", n), 32'(err), v.ok ? 32'(0) : 32'(1));
         end
      end
      step();
      req_valid = '0;
      stuck     = 1'b0;
      sample();
      check_output($sformatf("v%0d done busy", n), 32'(busy), 32'(0));
   endtask

   // Transaction-level model: a grant starts in an idle cycle, lasts 2 cycles
   // (success) or 2*MAX_RETRY cycles (abort), then the pointer moves to it.
   task automatic run_random(input int cycles, input logic stuck_mode);
      int                 m_ptr;
      int                 m_grant;
      int                 m_start;
      int                 m_len;
      int                 idx;
      logic [DATA_W-1:0]  m_data;
      logic               m_active;
      logic               m_ok;
      logic [NUM_REQ-1:0] done;
      logic [NUM_REQ-1:0] exp_ready;
      logic               exp_err;
`ifdef ARB_GRANT_CNT_EN
      logic [15:0]        m_count;
      m_count = '0;
`endif
      m_ptr    = NUM_REQ - 1;
      m_grant  = 0;
      m_start  = 0;
      m_len    = 0;
      idx      = 0;
      m_data   = '0;
      m_active = 1'b0;
      m_ok     = 1'b0;
      done     = '0;
      stuck    = stuck_mode;
      for (int t = 0; t < cycles; t++) begin
         step();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (done[i]) begin
               req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
               req_valid[i] = 1'b1;
               req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
         end
         exp_ready = '0;
         exp_err   = 1'b0;
         if (m_active && (t - m_start == m_len)) begin
            if (m_ok) begin
               exp_ready = NUM_REQ'(1) << m_grant;
            end else begin
               exp_err = 1'b1;
            end
         end
         sample();
         check_output($sformatf("rand t%0d busy", t), 32'(busy), 32'(m_active));
         check_output($sformatf("rand t%0d grant_id", t), 32'(grant_id), 32'(m_grant));
         check_output($sformatf("rand t%0d reg_wdata", t), 32'(reg_wdata), 32'(m_data));
         check_output($sformatf("rand t%0d ready", t), 32'(req_ready), 32'(exp_ready));
         check_output($sformatf("rand t%0d err", t), 32'(err), 32'(exp_err));
`ifdef ARB_GRANT_CNT_EN
         check_output($sformatf("rand t%0d grant_count", t), 32'(grant_count), 32'(m_count));
`endif
         done = exp_ready;
         if (m_active) begin
            if (t - m_start == m_len) begin
               m_active = 1'b0;
               m_ptr    = m_grant;
`ifdef ARB_GRANT_CNT_EN
               if (m_ok && (m_count != 16'hFFFF)) begin
                  m_count = m_count + 16'd1;
               end
`endif
            end
         end else if (req_valid != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               idx = (m_ptr + k) % NUM_REQ;
               if (req_valid[idx]) begin
                  break;
               end
            end
            m_grant  = idx;
            m_data   = req_data[idx*DATA_W +: DATA_W];
            m_ok     = !stuck_mode || (m_data == '0);
            m_len    = m_ok ? 2 : 2 * MAX_RETRY;
            m_start  = t;
            m_active = 1'b1;
         end
      end
      req_valid = '0;
      stuck     = 1'b0;
   endtask

   // Main sequence: reset state, vector table, hand-written corners, random phases.
   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      stuck     = 1'b0;

      vecs[0] = '{4'b0010, 16'h00A0, 1'b0, 1, 4'hA, 1'b1};
      vecs[1] = '{4'b1111, 16'h4321, 1'b0, 2, 4'h3, 1'b1};
      vecs[2] = '{4'b0001, 16'h0009, 1'b0, 0, 4'h9, 1'b1};
      vecs[3] = '{4'b1001, 16'hC00D, 1'b0, 3, 4'hC, 1'b1};
      vecs[4] = '{4'b1001, 16'hC00D, 1'b0, 0, 4'hD, 1'b1};
      vecs[5] = '{4'b1000, 16'h5000, 1'b1, 3, 4'h5, 1'b0};
      vecs[6] = '{4'b0111, 16'h0321, 1'b0, 0, 4'h1, 1'b1};
      vecs[7] = '{4'b0100, 16'h0000, 1'b1, 2, 4'h0, 1'b1};
      vecs[8] = '{4'b0110, 16'h0770, 1'b0, 1, 4'h7, 1'b1};
      vecs[9] = '{4'b0010, 16'h0070, 1'b0, 1, 4'h7, 1'b1};

      #2;
      do_reset();
      sample();
      check_output("reset reg_wdata", 32'(reg_wdata), 32'(0));
      check_output("reset grant_id", 32'(grant_id), 32'(0));
      check_output("reset busy", 32'(busy), 32'(0));
      check_output("reset err", 32'(err), 32'(0));
      check_output("reset ready", 32'(req_ready), 32'(0));
`ifdef ARB_GRANT_CNT_EN
      check_output("reset grant_count", 32'(grant_count), 32'(0));
`endif

      for (int n = 0; n < 10; n++) begin
         apply_stimulus(vecs[n], n);
      end

      // All requesters valid and held: strict rotation 0,1,2,3 every 3 cycles.
      do_reset();
      step();
      req_valid = 4'b1111;
      req_data  = 16'h4321;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) step();
         sample();
         check_output($sformatf("all c%0d ready", c), 32'(req_ready),
                      (c % 3 == 2) ? 32'(4'(1) << (c / 3)) : 32'(0));
         if (c % 3 == 1) begin
            check_output($sformatf("all c%0d reg_wdata", c), 32'(reg_wdata), 32'(c / 3 + 1));
         end
      end

      // Requesters 0 and 2 held: grants alternate, 1 and 3 never served.
      do_reset();
      step();
      req_valid = 4'b0101;
      req_data  = 16'h0B0A;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) step();
         sample();
         check_output($sformatf("alt c%0d ready", c), 32'(req_ready),
                      (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 32'(1) : 32'(4)) : 32'(0));
      end

      // Granted requester drops valid mid-grant: ready still pulses.
      do_reset();
      step();
      req_valid = 4'b0010;
      req_data  = 16'h0020;
      step();
      req_valid = '0;
      sample();
      step();
      sample();
      check_output("drop ready", 32'(req_ready), 32'(4'b0010));
      step();
      sample();
      check_output("drop busy", 32'(busy), 32'(0));

      // Reset during CHECK of requester 2; afterwards requester 0 wins first.
      do_reset();
      step();
      req_valid = 4'b0100;
      req_data  = 16'h0603;
      sample();
      step();
      sample();
      step();
      sample();
      check_output("midrst check ready", 32'(req_ready), 32'(4'b0100));
      #1;
      reset = 1'b1;
      #1;
      check_output("midrst reg_wdata", 32'(reg_wdata), 32'(0));
      check_output("midrst ready", 32'(req_ready), 32'(0));
      check_output("midrst err", 32'(err), 32'(0));
      check_output("midrst busy", 32'(busy), 32'(0));
      req_valid = 4'b0101;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sample();
      check_output("midrst idle busy", 32'(busy), 32'(0));
      step();
      sample();
      check_output("midrst grant_id", 32'(grant_id), 32'(0));
      check_output("midrst reg_wdata after", 32'(reg_wdata), 32'(3));

      do_reset();
      run_random(300, 1'b0);
      do_reset();
      run_random(300, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
